// File: rtl/block_data_memory.sv
// Block-addressed data memory (64 x 32-bit blocks, byte storage) with a fixed,
// parameterised access latency and a busy/wait handshake toward the cache miss controller.
module block_data_memory #(
    parameter int unsigned LATENCY = 5
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [5:0]  ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT
);

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_write_q;
    logic [5:0]  addr_q;
    logic [31:0] wdata_q;
    logic        capture;
    logic        complete;

    logic [7:0]  mem [256];
    logic [7:0]  base;

    assign base = {addr_q, 2'b00};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        complete = 1'b0;
        BUSYWAIT = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Busy is combinational here so the requester sees it in the same timestep.
                BUSYWAIT = (READ ^ WRITE) & ~RESET;
                if (READ ^ WRITE) begin
                    capture = 1'b1;
                    cnt_d   = CntInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                BUSYWAIT = 1'b1;
                if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            addr_q     <= 6'd0;
            wdata_q    <= 32'd0;
            READDATA   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                op_write_q <= WRITE;
                addr_q     <= ADDRESS;
                wdata_q    <= WRITEDATA;
            end
            if (complete && !op_write_q) begin
                READDATA <= {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
            end
        end
    end

    // Storage is deliberately outside the reset domain: reset never clears contents.
    always_ff @(posedge CLOCK) begin
        if (complete && op_write_q && !RESET) begin
            mem[base]        <= wdata_q[7:0];
            mem[base + 8'd1] <= wdata_q[15:8];
            mem[base + 8'd2] <= wdata_q[23:16];
            mem[base + 8'd3] <= wdata_q[31:24];
        end
    end

endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench for block_data_memory: transaction-level reference model plus
// directed scenarios with literal expectations and a randomized soak phase.
module tb_block_data_memory;

    localparam int unsigned LATENCY = 5;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [5:0]  ADDRESS = 6'd0;
    logic [31:0] WRITEDATA = 32'd0;
    logic [31:0] READDATA;
    logic        BUSYWAIT;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    block_data_memory #(.LATENCY(LATENCY)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .READ(READ),
        .WRITE(WRITE),
        .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation in flight is just "edges elapsed since it was accepted";
    // it completes when LATENCY edges have passed, then one quiet cycle follows.
    int          m_age = -1;
    bit          m_quiet = 1'b0;
    logic [31:0] m_rd = 32'd0;
    logic [31:0] m_mem [64];
    bit          m_wr = 1'b0;
    logic [5:0]  m_a = 6'd0;
    logic [31:0] m_d = 32'd0;

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            m_age   = -1;
            m_quiet = 1'b0;
            m_rd    = 32'd0;
        end else if (m_age >= 0) begin
            m_age++;
            if (m_age == int'(LATENCY)) begin
                if (m_wr) m_mem[m_a] = m_d;
                else      m_rd = m_mem[m_a];
                m_age   = -1;
                m_quiet = 1'b1;
            end
        end else if (m_quiet) begin
            m_quiet = 1'b0;
        end else if (READ ^ WRITE) begin
            m_wr  = WRITE;
            m_a   = ADDRESS;
            m_d   = WRITEDATA;
            m_age = 0;
        end
    end

    function automatic logic exp_busy();
        if (RESET) return 1'b0;
        if (m_age >= 0) return 1'b1;
        if (m_quiet) return 1'b0;
        return READ ^ WRITE;
    endfunction

    always @(negedge CLOCK) begin
        if (chk_en) begin
            chk("busywait", 32'(BUSYWAIT), 32'(exp_busy()));
            chk("readdata", READDATA, m_rd);
        end
    end

    // Raise a request just after an edge, confirm immediate busy, and return just after E0.
    task automatic start_req(input bit wr, input logic [5:0] a, input logic [31:0] d);
        @(posedge CLOCK);
        #1;
        READ      = !wr;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = d;
        #1 chk("busy_on_request", 32'(BUSYWAIT), 32'd1);
        @(posedge CLOCK);
        #1;
    endtask

    // Count busy negedges after E0; drop the request after 'hold' further edges unless 'keep'.
    // Returns at the negedge inside the one-cycle quiet period.
    task automatic run_access(input int hold, input bit keep, output int n);
        bit seen_low = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK);
            if (i == hold && !keep) begin
                READ  = 1'b0;
                WRITE = 1'b0;
            end
            if (!BUSYWAIT) begin
                seen_low = 1'b1;
                break;
            end
            n++;
        end
        if (!seen_low) chk("access_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input bit wr, input logic [5:0] a, input logic [31:0] d, input int hold);
        int n;
        start_req(wr, a, d);
        run_access(hold, 1'b0, n);
        chk("busy_cycles", 32'(n), 32'(LATENCY));
        @(negedge CLOCK);
        chk("idle_after_done", 32'(BUSYWAIT), 32'd0);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] exp, input string name);
        do_op(1'b0, a, 32'd0, 0);
        chk(name, READDATA, exp);
    endtask

    initial begin
        int n;
        logic [31:0] saved;

        #2 RESET = 1'b1;
        #10 RESET = 1'b0;
        chk_en = 1'b1;
        chk("reset_readdata", READDATA, 32'd0);
        chk("reset_busy", 32'(BUSYWAIT), 32'd0);

        // Give every block a known value.
        for (int a = 0; a < 64; a++) begin
            do_op(1'b1, 6'(a), $urandom, int'($urandom_range(0, 3)));
        end

        // Write then read.
        do_op(1'b1, 6'h05, 32'hDEADBEEF, 0);
        do_read(6'h05, 32'hDEADBEEF, "write_read_05");

        // Back-to-back writes with the request held across the quiet cycle.
        start_req(1'b1, 6'h00, 32'h11111111);
        run_access(0, 1'b1, n);
        chk("b2b_first_cycles", 32'(n), 32'(LATENCY));
        ADDRESS   = 6'h3F;
        WRITEDATA = 32'h3F3F3F3F;
        @(posedge CLOCK);
        #1 chk("busy_reasserts_idle", 32'(BUSYWAIT), 32'd1);
        @(posedge CLOCK);
        #1;
        run_access(0, 1'b0, n);
        chk("b2b_second_cycles", 32'(n), 32'(LATENCY));
        @(negedge CLOCK);
        do_read(6'h00, 32'h11111111, "isolation_00");
        do_read(6'h3F, 32'h3F3F3F3F, "isolation_3f");

        // Both request lines high is not a request.
        @(posedge CLOCK);
        #1;
        READ    = 1'b1;
        WRITE   = 1'b1;
        ADDRESS = 6'h00;
        saved   = READDATA;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            chk("illegal_busy", 32'(BUSYWAIT), 32'd0);
        end
        READ  = 1'b0;
        WRITE = 1'b0;
        chk("illegal_readdata", READDATA, saved);
        do_read(6'h00, 32'h11111111, "illegal_storage_00");

        // Asynchronous reset mid-cycle.
        @(posedge CLOCK);
        #2 RESET = 1'b1;
        #1;
        chk("async_reset_busy", 32'(BUSYWAIT), 32'd0);
        chk("async_reset_readdata", READDATA, 32'd0);
        #1 RESET = 1'b0;

        // Reset between E2 and E3 aborts a write.
        do_op(1'b1, 6'h0A, 32'hCAFEF00D, 0);
        start_req(1'b1, 6'h0A, 32'h12345678);
        READ  = 1'b0;
        WRITE = 1'b0;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #3 RESET = 1'b1;
        #1 chk("abort_busy", 32'(BUSYWAIT), 32'd0);
        #1 RESET = 1'b0;
        @(negedge CLOCK);
        do_read(6'h0A, 32'hCAFEF00D, "abort_storage_0a");

        // Read dropped after E1 still completes.
        do_op(1'b1, 6'h21, 32'hA5A55A5A, 0);
        do_op(1'b0, 6'h21, 32'd0, 1);
        chk("dropped_read", READDATA, 32'hA5A55A5A);

        // Randomized soak: inputs change every cycle, occasional mid-cycle reset.
        for (int c = 0; c < 2000; c++) begin
            @(posedge CLOCK);
            #1;
            READ      = ($urandom_range(0, 2) == 0);
            WRITE     = ($urandom_range(0, 2) == 0);
            ADDRESS   = 6'($urandom_range(0, 7) * 9);
            WRITEDATA = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                #1 RESET = 1'b1;
                #1 RESET = 1'b0;
            end
        end
        READ  = 1'b0;
        WRITE = 1'b0;
        repeat (LATENCY + 3) @(negedge CLOCK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_data_memory.md
BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 Parameter: LATENCY, default 5, memory access time in CLOCK cycles; legal range 2..15.
REQ-002 Port: CLOCK  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: RESET  input  1  asynchronous, active-high reset.
REQ-004 Port: READ  input  1  block read request from the cache miss controller.
REQ-005 Port: WRITE  input  1  block write-back request from the cache miss controller.
REQ-006 Port: ADDRESS  input  6  block address (64 blocks of 4 bytes).
REQ-007 Port: WRITEDATA  input  32  block to store.
REQ-008 Port: READDATA  output  32  block fetched by the last completed read.
REQ-009 Port: BUSYWAIT  output  1  high while a request is pending or in progress.
REQ-010 Clocking and reset are fixed: one clock (CLOCK); RESET is asynchronous and active-high.

Function
REQ-011 Storage shall be 256 bytes; block b shall occupy bytes 4b..4b+3, with data bits [7:0] mapped to byte 4b and bits [31:24] to byte 4b+3.
REQ-012 The FSM shall have three states: IDLE, ACCESS and DONE, with a 4-bit down-counter CNT.
REQ-013 In IDLE, BUSYWAIT shall equal READ XOR WRITE combinationally, so the requester sees busy in the same timestep it raises a request.
REQ-014 At an IDLE rising edge with exactly one of READ/WRITE high: latch the operation, ADDRESS and WRITEDATA; set CNT=LATENCY-1; go to ACCESS. This edge is E0.
REQ-015 At an IDLE edge with READ and WRITE both high or both low: remain in IDLE, hold BUSYWAIT=0, change no storage.
REQ-016 ACCESS shall hold BUSYWAIT=1 and ignore READ, WRITE, ADDRESS and WRITEDATA; only latched values are used.
REQ-017 ACCESS edge with CNT!=0: decrement CNT.
REQ-018 ACCESS edge with CNT==0 (edge E_LATENCY):
- read: load READDATA from the latched block;
- write: store the latched data to the latched block;
- go to DONE.
REQ-019 DONE shall hold BUSYWAIT=0 for exactly one cycle, then go to IDLE at the next edge unconditionally; requests are not sampled in DONE.
REQ-020 A request still high on re-entry to IDLE shall raise BUSYWAIT per REQ-013 and start a new access.
REQ-021 READDATA shall change only on read completion and shall hold its value through writes, idle periods and DONE.
REQ-022 A request dropped during ACCESS shall not abort the operation; it completes per REQ-018.
REQ-023 Total busy time is LATENCY cycles from E0; a read-after-write to the same block shall return the written data.

Reset
REQ-024 RESET high shall immediately force state IDLE, CNT=0, BUSYWAIT=0 and READDATA=32'h0, independent of CLOCK.
REQ-025 Reset during ACCESS shall abort the operation: a pending write shall not modify storage and a pending read shall not update READDATA.
REQ-026 Reset shall not clear storage contents.
REQ-027 While RESET is high, no request shall be captured.

Verification (LATENCY=5)
REQ-028 Reset check: assert RESET mid-cycle -> BUSYWAIT=0 and READDATA=0 immediately.
REQ-029 Write then read:
- WRITE block 6'h05 with 32'hDEADBEEF -> BUSYWAIT high from request through E5, low exactly one cycle;
- then READ 6'h05 -> READDATA=32'hDEADBEEF after E5.
REQ-030 Address isolation: write 32'h11111111 to 6'h00 and 32'h3F3F3F3F to 6'h3F, back-to-back -> reads return each value, with BUSYWAIT re-asserting in IDLE per REQ-020.
REQ-031 Illegal request: READ=WRITE=1 for 3 cycles -> BUSYWAIT=0, storage and READDATA unchanged.
REQ-032 Reset abort: 6'h0A holds 32'hCAFEF00D; WRITE 32'h12345678 to 6'h0A; pulse RESET between E2 and E3 -> BUSYWAIT=0 at once; a later read returns 32'hCAFEF00D.
REQ-033 Dropped request: READ deasserted after E1 -> access still completes at E5, READDATA updates, DONE lasts one cycle, then IDLE.
